// File: rtl/dispatch_unit_pq.sv
// -----------------------------------------------------------------------------
// dispatch_unit_pq
//
// Purpose:
//   Single-issue dispatcher feeding NUM_Q issue queues. Each cycle it pops the
//   IFQ head, decodes it, and resolves rs/rt through an internal register
//   status table (RST). The RST forwards from the CDB and from the retiring
//   instruction. The unit allocates a destination tag from a free-tag FIFO and
//   writes a one-hot strobe to the selected issue queue. Plain jumps (j) are
//   executed here: the unit sends a one-cycle redirect to the IFQ and then
//   spends one FLUSH cycle ignoring the stale head.
//
// Optional feature (compile-time macro DISPATCH_JAL_EN):
//   When defined, jal (opcode 0x03) redirects like j. It also allocates a tag
//   for r31 and dispatches to q0 with rs = pc_4+4 and rt = 0 (both ready).
//   When undefined, opcode 0x03 is treated as a generic I-type to q0.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-low reset
//   ifetch_*                 IFQ head (pc+4, instruction, empty flag)
//   Dispatch_ren             combinational head-consume strobe
//   Dispatch_jmp/_jmp_addr   registered redirect pulse and target
//   issueque_full            per-queue full flags
//   dispatch_*               registered queue write payload (strobe, instr,
//                            operands, tags, dest tag/valid)
//   regfile_*                async register-file read port
//   Cdb_*                    common data bus broadcast
//   Retire_*                 ROB retire (frees tag, clears RST entry)
//   free_tag_count           tags available in the free pool
// -----------------------------------------------------------------------------
module dispatch_unit_pq #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5,
   parameter int NUM_Q  = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       ifetch_pc_4,
   input  logic [31:0]       ifetch_intruction,
   input  logic              ifetch_empty,
   output logic              Dispatch_ren,
   output logic              Dispatch_jmp,
   output logic [31:0]       Dispatch_jmp_addr,
   input  logic [NUM_Q-1:0]  issueque_full,
   output logic [NUM_Q-1:0]  dispatch_en,
   output logic [31:0]       dispatch_instr,
   output logic [DATA_W-1:0] dispatch_rs_data,
   output logic [DATA_W-1:0] dispatch_rt_data,
   output logic              dispatch_rs_data_valid,
   output logic              dispatch_rt_data_valid,
   output logic [TAG_W-1:0]  dispatch_rs_tag,
   output logic [TAG_W-1:0]  dispatch_rt_tag,
   output logic [TAG_W-1:0]  dispatch_rd_tag,
   output logic              dispatch_rd_valid,
   output logic [4:0]        regfile_rs_addr,
   output logic [4:0]        regfile_rt_addr,
   input  logic [DATA_W-1:0] regfile_rs_data,
   input  logic [DATA_W-1:0] regfile_rt_data,
   input  logic              Cdb_valid,
   input  logic [TAG_W-1:0]  Cdb_rd_tag,
   input  logic [DATA_W-1:0] Cdb_data,
   input  logic              Retire_valid,
   input  logic [TAG_W-1:0]  Retire_rd_tag,
   input  logic [4:0]        Retire_rd_reg,
   input  logic [DATA_W-1:0] Retire_data,
   output logic [TAG_W:0]    free_tag_count
);

   localparam int DEPTH = 2**TAG_W;
   localparam int Q_LS  = (NUM_Q >= 2) ? 1 : 0;
   localparam int Q_MUL = (NUM_Q >= 3) ? 2 : 0;
   localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] F_MULT   = 6'h18;
   localparam logic [5:0] F_MULTU  = 6'h19;
`ifdef DISPATCH_JAL_EN
   localparam logic [5:0] OP_JAL   = 6'h03;
`endif

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              valid;
      logic [TAG_W-1:0]  tag;
   } operand_t;

   state_t state_q, state_d;

   // Register status table
   logic [31:0]      rst_busy_q;
   logic [TAG_W-1:0] rst_tag_q [32];

   // Free-tag FIFO
   logic [TAG_W-1:0] fifo_q [DEPTH];
   logic [TAG_W-1:0] head_q, tail_q;
   logic [TAG_W:0]   cnt_q, cnt_d;

   // Registered outputs
   logic [NUM_Q-1:0]  en_q;
   logic              jmp_q;
   logic [31:0]       jmp_addr_q;
   logic [31:0]       instr_q;
   operand_t          rs_q, rt_q;
   logic [TAG_W-1:0]  rd_tag_q;
   logic              rd_valid_q;

   // Decode
   logic [5:0]       opcode, funct;
   logic [4:0]       rs_reg, rt_reg, rd_reg, dest_reg;
   logic [NUM_Q-1:0] q_oh;
   logic             writes_reg, is_jump, is_jal;
   logic             has_dest, local_jump, q_ready, tag_ok, dispatch;
   logic             pop, push;
   logic [31:0]      jump_target;
   operand_t         rs_res, rt_res;

   assign opcode = ifetch_intruction[31:26];
   assign rs_reg = ifetch_intruction[25:21];
   assign rt_reg = ifetch_intruction[20:16];
   assign rd_reg = ifetch_intruction[15:11];
   assign funct  = ifetch_intruction[5:0];

   assign regfile_rs_addr = rs_reg;
   assign regfile_rt_addr = rt_reg;

   always_comb begin
      q_oh       = '0;
      q_oh[0]    = 1'b1;
      dest_reg   = rt_reg;
      writes_reg = 1'b1;
      is_jump    = 1'b0;
      is_jal     = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dest_reg = rd_reg;
            if (funct == F_MULT || funct == F_MULTU) begin
               q_oh        = '0;
               q_oh[Q_MUL] = 1'b1;
            end
         end
         OP_LW: begin
            q_oh       = '0;
            q_oh[Q_LS] = 1'b1;
         end
         OP_SW: begin
            q_oh       = '0;
            q_oh[Q_LS] = 1'b1;
            writes_reg = 1'b0;
         end
         OP_BEQ, OP_BNE: writes_reg = 1'b0;
         OP_J: begin
            q_oh       = '0;
            writes_reg = 1'b0;
            is_jump    = 1'b1;
         end
`ifdef DISPATCH_JAL_EN
         OP_JAL: begin
            dest_reg = 5'd31;
            is_jump  = 1'b1;
            is_jal   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Writes to r0 are discarded, so they never need a tag.
   assign has_dest    = writes_reg && (dest_reg != 5'd0);
   assign local_jump  = is_jump && !is_jal;
   assign q_ready     = local_jump || ((issueque_full & q_oh) == '0);
   // No bypass from a same-cycle retire into an empty pool: the stall is
   // driven purely by the registered count.
   assign tag_ok      = !has_dest || (cnt_q != '0);
   assign dispatch    = (state_q == S_RUN) && !ifetch_empty && q_ready && tag_ok;
   assign Dispatch_ren = dispatch;

   assign pop  = dispatch && has_dest;
   assign push = Retire_valid && (cnt_q != CNT_FULL);

   assign jump_target = {ifetch_pc_4[31:28], ifetch_intruction[25:0], 2'b00};

`ifndef DISPATCH_JAL_EN
   logic unused_pc_bits;
   assign unused_pc_bits = ^ifetch_pc_4[27:0];
`endif

   // Operand priority: r0, idle RST entry, CDB hit, retire hit, else wait on tag.
   function automatic operand_t resolve_src(
      input logic [4:0]        src,
      input logic [DATA_W-1:0] rf_data,
      input logic              busy,
      input logic [TAG_W-1:0]  tag
   );
      operand_t o;
      o.data  = '0;
      o.valid = 1'b1;
      o.tag   = '0;
      if (src != 5'd0) begin
         if (!busy)
            o.data = rf_data;
         else if (Cdb_valid && Cdb_rd_tag == tag)
            o.data = Cdb_data;
         else if (Retire_valid && Retire_rd_tag == tag)
            o.data = Retire_data;
         else begin
            o.valid = 1'b0;
            o.tag   = tag;
         end
      end
      return o;
   endfunction

   always_comb begin
      rs_res = resolve_src(rs_reg, regfile_rs_data, rst_busy_q[rs_reg], rst_tag_q[rs_reg]);
      rt_res = resolve_src(rt_reg, regfile_rt_data, rst_busy_q[rt_reg], rst_tag_q[rt_reg]);
`ifdef DISPATCH_JAL_EN
      if (is_jal) begin
         rs_res.data  = DATA_W'(ifetch_pc_4 + 32'd4);
         rs_res.valid = 1'b1;
         rs_res.tag   = '0;
         rt_res.data  = '0;
         rt_res.valid = 1'b1;
         rt_res.tag   = '0;
      end
`endif
   end

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + 1'b1;
      else if (pop && !push)
         cnt_d = cnt_q - 1'b1;
   end

   // FSM: a jump spends exactly one FLUSH cycle discarding the stale head.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (dispatch && is_jump) state_d = S_FLUSH;
         S_FLUSH: state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         en_q       <= '0;
         jmp_q      <= 1'b0;
         jmp_addr_q <= '0;
         instr_q    <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_tag_q   <= '0;
         rd_valid_q <= 1'b0;
         rst_busy_q <= '0;
         for (int i = 0; i < 32; i++) rst_tag_q[i] <= '0;
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= TAG_W'(i);
         head_q     <= '0;
         tail_q     <= '0;
         cnt_q      <= CNT_FULL;
      end else begin
         en_q  <= '0;
         jmp_q <= dispatch && is_jump;
         if (dispatch && is_jump)
            jmp_addr_q <= jump_target;
         if (dispatch && !local_jump) begin
            en_q       <= q_oh;
            instr_q    <= ifetch_intruction;
            rs_q       <= rs_res;
            rt_q       <= rt_res;
            rd_tag_q   <= has_dest ? fifo_q[head_q] : '0;
            rd_valid_q <= has_dest;
         end

         // Retire clear is issued first so a same-cycle dispatch to the same
         // register overrides it.
         if (Retire_valid && rst_busy_q[Retire_rd_reg] &&
             rst_tag_q[Retire_rd_reg] == Retire_rd_tag)
            rst_busy_q[Retire_rd_reg] <= 1'b0;
         if (pop) begin
            rst_busy_q[dest_reg] <= 1'b1;
            rst_tag_q[dest_reg]  <= fifo_q[head_q];
            head_q               <= head_q + 1'b1;
         end

         if (push) begin
            fifo_q[tail_q] <= Retire_rd_tag;
            tail_q         <= tail_q + 1'b1;
         end
         cnt_q <= cnt_d;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clock) begin
      if (reset && Retire_valid && cnt_q == CNT_FULL)
         $error("dispatch_unit_pq: tag %0d returned to a full free pool, ignored", Retire_rd_tag);
   end
`endif

   assign Dispatch_jmp           = jmp_q;
   assign Dispatch_jmp_addr      = jmp_addr_q;
   assign dispatch_en            = en_q;
   assign dispatch_instr         = instr_q;
   assign dispatch_rs_data       = rs_q.data;
   assign dispatch_rs_data_valid = rs_q.valid;
   assign dispatch_rs_tag        = rs_q.tag;
   assign dispatch_rt_data       = rt_q.data;
   assign dispatch_rt_data_valid = rt_q.valid;
   assign dispatch_rt_tag        = rt_q.tag;
   assign dispatch_rd_tag        = rd_tag_q;
   assign dispatch_rd_valid      = rd_valid_q;
   assign free_tag_count         = cnt_q;

endmodule

// File: tb/tb_dispatch_unit_pq.sv
`timescale 1ns/1ps
module tb_dispatch_unit_pq;
   localparam int DATA_W = 32;
   localparam int TAG_W  = 5;
   localparam int NUM_Q  = 3;
   localparam int DEPTH  = 32;

   localparam logic [31:0] I_ADD = 32'h00221820; // add r3,r1,r2
   localparam logic [31:0] I_SUB = 32'h00612022; // sub r4,r3,r1
   localparam logic [31:0] I_LW  = 32'h8C250000; // lw  r5,0(r1)
   localparam logic [31:0] I_J   = 32'h08000040; // j   0x0000040

   logic              clock = 1'b0;
   logic              reset;
   logic [31:0]       ifetch_pc_4, ifetch_intruction;
   logic              ifetch_empty;
   logic              Dispatch_ren, Dispatch_jmp;
   logic [31:0]       Dispatch_jmp_addr;
   logic [NUM_Q-1:0]  issueque_full, dispatch_en;
   logic [31:0]       dispatch_instr;
   logic [DATA_W-1:0] dispatch_rs_data, dispatch_rt_data;
   logic              dispatch_rs_data_valid, dispatch_rt_data_valid;
   logic [TAG_W-1:0]  dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag;
   logic              dispatch_rd_valid;
   logic [4:0]        regfile_rs_addr, regfile_rt_addr;
   logic [DATA_W-1:0] regfile_rs_data, regfile_rt_data;
   logic              Cdb_valid;
   logic [TAG_W-1:0]  Cdb_rd_tag;
   logic [DATA_W-1:0] Cdb_data;
   logic              Retire_valid;
   logic [TAG_W-1:0]  Retire_rd_tag;
   logic [4:0]        Retire_rd_reg;
   logic [DATA_W-1:0] Retire_data;
   logic [TAG_W:0]    free_tag_count;

   always #5 clock = ~clock;

   dispatch_unit_pq #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_Q(NUM_Q)) dut (
      .clock(clock), .reset(reset),
      .ifetch_pc_4(ifetch_pc_4), .ifetch_intruction(ifetch_intruction),
      .ifetch_empty(ifetch_empty), .Dispatch_ren(Dispatch_ren),
      .Dispatch_jmp(Dispatch_jmp), .Dispatch_jmp_addr(Dispatch_jmp_addr),
      .issueque_full(issueque_full), .dispatch_en(dispatch_en),
      .dispatch_instr(dispatch_instr),
      .dispatch_rs_data(dispatch_rs_data), .dispatch_rt_data(dispatch_rt_data),
      .dispatch_rs_data_valid(dispatch_rs_data_valid),
      .dispatch_rt_data_valid(dispatch_rt_data_valid),
      .dispatch_rs_tag(dispatch_rs_tag), .dispatch_rt_tag(dispatch_rt_tag),
      .dispatch_rd_tag(dispatch_rd_tag), .dispatch_rd_valid(dispatch_rd_valid),
      .regfile_rs_addr(regfile_rs_addr), .regfile_rt_addr(regfile_rt_addr),
      .regfile_rs_data(regfile_rs_data), .regfile_rt_data(regfile_rt_data),
      .Cdb_valid(Cdb_valid), .Cdb_rd_tag(Cdb_rd_tag), .Cdb_data(Cdb_data),
      .Retire_valid(Retire_valid), .Retire_rd_tag(Retire_rd_tag),
      .Retire_rd_reg(Retire_rd_reg), .Retire_data(Retire_data),
      .free_tag_count(free_tag_count)
   );

   // Register file model
   logic [31:0] rf [32];
   assign regfile_rs_data = rf[regfile_rs_addr];
   assign regfile_rt_data = rf[regfile_rt_addr];

   // Reference model state
   typedef struct { int reg_n; int tag; } outst_t;
   bit     m_busy [32];
   int     m_tag  [32];
   int     m_pool [$];
   bit     m_flush;
   outst_t outst  [$];

   // Expected outputs after the next edge
   logic             e_ren, a_ren;
   logic [NUM_Q-1:0] e_en;
   logic             e_jmp;
   logic [31:0]      e_jaddr, e_instr, e_rs_d, e_rt_d;
   logic             e_rs_v, e_rt_v, e_rd_v;
   logic [4:0]       e_rs_t, e_rt_t, e_rd_t;
   int               e_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
      m_pool.delete();
      for (int i = 0; i < DEPTH; i++) m_pool.push_back(i);
      outst.delete();
      m_flush = 0;
      e_ren = 0; e_en = '0; e_jmp = 0; e_jaddr = '0; e_instr = '0;
      e_rs_d = '0; e_rt_d = '0; e_rs_v = 0; e_rt_v = 0;
      e_rs_t = '0; e_rt_t = '0; e_rd_t = '0; e_rd_v = 0; e_cnt = DEPTH;
   endtask

   task automatic resolve(input int r, output logic [31:0] d, output logic v, output logic [4:0] t);
      d = '0; v = 1; t = '0;
      if (r == 0) d = '0;
      else if (!m_busy[r]) d = rf[r];
      else if (Cdb_valid && int'(Cdb_rd_tag) == m_tag[r]) d = Cdb_data;
      else if (Retire_valid && int'(Retire_rd_tag) == m_tag[r]) d = Retire_data;
      else begin v = 0; t = 5'(m_tag[r]); end
   endtask

   task automatic model_step();
      logic [31:0] ins;
      int op, fn, rs, rt, rd, q, dest, sz0, new_tag;
      bit wr, jmp, jal, has_dest, go;
      ins = ifetch_intruction;
      op = int'(ins[31:26]); fn = int'(ins[5:0]);
      rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
      q = 0; dest = rt; wr = 1; jmp = 0; jal = 0;
      if (op == 0) begin
         dest = rd;
         if (fn == 'h18 || fn == 'h19) q = (NUM_Q >= 3) ? 2 : 0;
      end
      else if (op == 'h23) q = 1;
      else if (op == 'h2b) begin q = 1; wr = 0; end
      else if (op == 'h04 || op == 'h05) wr = 0;
      else if (op == 'h02) begin jmp = 1; wr = 0; q = -1; end
`ifdef DISPATCH_JAL_EN
      else if (op == 'h03) begin jmp = 1; jal = 1; dest = 31; end
`endif
      has_dest = wr && dest != 0;
      go = !m_flush && !ifetch_empty && (q < 0 || !issueque_full[q]) &&
           (!has_dest || m_pool.size() > 0);
      new_tag = (go && has_dest) ? m_pool[0] : 0;
      e_ren = go; e_jmp = go && jmp; e_en = '0;
      if (go && jmp) e_jaddr = {ifetch_pc_4[31:28], ins[25:0], 2'b00};
      if (go && q >= 0) begin
         e_en = NUM_Q'(1) << q;
         e_instr = ins;
         resolve(rs, e_rs_d, e_rs_v, e_rs_t);
         resolve(rt, e_rt_d, e_rt_v, e_rt_t);
         if (jal) begin
            e_rs_d = ifetch_pc_4 + 4; e_rs_v = 1; e_rs_t = '0;
            e_rt_d = '0; e_rt_v = 1; e_rt_t = '0;
         end
         e_rd_v = has_dest;
         e_rd_t = 5'(new_tag);
      end
      sz0 = m_pool.size();
      if (Retire_valid && m_busy[Retire_rd_reg] && m_tag[Retire_rd_reg] == int'(Retire_rd_tag))
         m_busy[Retire_rd_reg] = 0;
      if (go && has_dest) begin
         void'(m_pool.pop_front());
         m_busy[dest] = 1; m_tag[dest] = new_tag;
         outst.push_back('{dest, new_tag});
      end
      if (Retire_valid && sz0 < DEPTH) m_pool.push_back(int'(Retire_rd_tag));
      m_flush = go && jmp;
      e_cnt = m_pool.size();
   endtask

   // One clock: sample combinational ren, advance the model, step past the edge.
   task automatic tick();
      #1;
      a_ren = Dispatch_ren;
      if (!reset) model_reset();
      else model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      ifetch_pc_4 = 32'h0000_0004; ifetch_intruction = '0; ifetch_empty = 1;
      issueque_full = '0; Cdb_valid = 0; Cdb_rd_tag = '0; Cdb_data = '0;
      Retire_valid = 0; Retire_rd_tag = '0; Retire_rd_reg = '0; Retire_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 0;
      tick(); tick();
      reset = 1;
   endtask

   task automatic test_reset();
      do_reset();
      if ({dispatch_en, Dispatch_jmp, dispatch_rd_valid, dispatch_rs_data_valid} !== '0) begin
         n_bad++; $display("FAIL reset_ctrl: got en=%b jmp=%b rdv=%b rsv=%b, want all 0",
            dispatch_en, Dispatch_jmp, dispatch_rd_valid, dispatch_rs_data_valid);
      end
      n_cmp++;
      if (free_tag_count !== 6'd32) begin
         n_bad++; $display("FAIL reset_count: got %0d want 32", free_tag_count);
      end
      n_cmp++;
      if ({Dispatch_jmp_addr, dispatch_instr, dispatch_rs_data, dispatch_rd_tag} !== '0) begin
         n_bad++; $display("FAIL reset_data: got addr=%h instr=%h rs=%h rdt=%0d want 0",
            Dispatch_jmp_addr, dispatch_instr, dispatch_rs_data, dispatch_rd_tag);
      end
      n_cmp++;
   endtask

   task automatic test_basic_add();
      do_reset();
      ifetch_empty = 0; ifetch_intruction = I_ADD;
      tick();
      ifetch_empty = 1;
      if (a_ren !== 1'b1) begin n_bad++; $display("FAIL add_ren: got %b want 1", a_ren); end
      n_cmp++;
      if (dispatch_en !== 3'b001) begin n_bad++; $display("FAIL add_en: got %b want 001", dispatch_en); end
      n_cmp++;
      if ({dispatch_rs_data, dispatch_rs_data_valid, dispatch_rt_data, dispatch_rt_data_valid} !== {32'd5, 1'b1, 32'd7, 1'b1}) begin
         n_bad++; $display("FAIL add_ops: got rs=%0d/%b rt=%0d/%b want 5/1 7/1",
            dispatch_rs_data, dispatch_rs_data_valid, dispatch_rt_data, dispatch_rt_data_valid);
      end
      n_cmp++;
      if ({dispatch_rd_tag, dispatch_rd_valid, free_tag_count} !== {5'd0, 1'b1, 6'd31}) begin
         n_bad++; $display("FAIL add_tag: got rdt=%0d rdv=%b cnt=%0d want 0 1 31",
            dispatch_rd_tag, dispatch_rd_valid, free_tag_count);
      end
      n_cmp++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      ifetch_empty = 0; ifetch_intruction = I_ADD;
      tick();
      ifetch_intruction = I_SUB;
      tick();
      ifetch_empty = 1;
      if ({dispatch_rs_data_valid, dispatch_rs_tag, dispatch_rs_data} !== {1'b0, 5'd0, 32'd0}) begin
         n_bad++; $display("FAIL b2b_rs: got v=%b tag=%0d data=%h want 0 0 0",
            dispatch_rs_data_valid, dispatch_rs_tag, dispatch_rs_data);
      end
      n_cmp++;
      if ({dispatch_rd_tag, dispatch_rt_data, dispatch_rt_data_valid} !== {5'd1, 32'd5, 1'b1}) begin
         n_bad++; $display("FAIL b2b_rd: got rdt=%0d rt=%0d/%b want 1 5/1",
            dispatch_rd_tag, dispatch_rt_data, dispatch_rt_data_valid);
      end
      n_cmp++;
   endtask

   task automatic test_cdb_forward();
      do_reset();
      ifetch_empty = 0; ifetch_intruction = I_ADD;
      tick();
      ifetch_intruction = I_SUB;
      Cdb_valid = 1; Cdb_rd_tag = 5'd0; Cdb_data = 32'h55;
      tick();
      ifetch_empty = 1; Cdb_valid = 0;
      if ({dispatch_rs_data, dispatch_rs_data_valid} !== {32'h55, 1'b1}) begin
         n_bad++; $display("FAIL cdb_fwd: got %h/%b want 00000055/1", dispatch_rs_data, dispatch_rs_data_valid);
      end
      n_cmp++;
   endtask

   task automatic test_queue_full();
      do_reset();
      ifetch_empty = 0; ifetch_intruction = I_LW; issueque_full = 3'b010;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (a_ren !== 1'b0 || dispatch_en !== 3'b000) begin
            n_bad++; $display("FAIL qfull_stall[%0d]: got ren=%b en=%b want 0 000", i, a_ren, dispatch_en);
         end
         n_cmp++;
      end
      issueque_full = '0;
      tick();
      ifetch_empty = 1;
      if (a_ren !== 1'b1 || dispatch_en !== 3'b010 || dispatch_rd_tag !== 5'd0 || dispatch_rd_valid !== 1'b1) begin
         n_bad++; $display("FAIL qfull_release: got ren=%b en=%b rdt=%0d rdv=%b want 1 010 0 1",
            a_ren, dispatch_en, dispatch_rd_tag, dispatch_rd_valid);
      end
      n_cmp++;
   endtask

   task automatic test_tag_exhaust();
      do_reset();
      ifetch_empty = 0; ifetch_intruction = I_ADD;
      for (int i = 0; i < DEPTH; i++) tick();
      if (free_tag_count !== 6'd0 || dispatch_rd_tag !== 5'd31) begin
         n_bad++; $display("FAIL exhaust_fill: got cnt=%0d rdt=%0d want 0 31", free_tag_count, dispatch_rd_tag);
      end
      n_cmp++;
      tick();
      if (a_ren !== 1'b0 || dispatch_en !== 3'b000) begin
         n_bad++; $display("FAIL exhaust_stall: got ren=%b en=%b want 0 000", a_ren, dispatch_en);
      end
      n_cmp++;
      Retire_valid = 1; Retire_rd_tag = 5'd7; Retire_rd_reg = 5'd3; Retire_data = 32'h77;
      tick();
      Retire_valid = 0;
      if (a_ren !== 1'b0 || free_tag_count !== 6'd1) begin
         n_bad++; $display("FAIL exhaust_nobypass: got ren=%b cnt=%0d want 0 1", a_ren, free_tag_count);
      end
      n_cmp++;
      tick();
      ifetch_empty = 1;
      if (a_ren !== 1'b1 || dispatch_en !== 3'b001 || dispatch_rd_tag !== 5'd7 || free_tag_count !== 6'd0) begin
         n_bad++; $display("FAIL exhaust_reuse: got ren=%b en=%b rdt=%0d cnt=%0d want 1 001 7 0",
            a_ren, dispatch_en, dispatch_rd_tag, free_tag_count);
      end
      n_cmp++;
   endtask

   task automatic test_jump();
      do_reset();
      ifetch_empty = 0; ifetch_pc_4 = 32'h1000_0004; ifetch_intruction = I_J;
      tick();
      if (a_ren !== 1'b1 || Dispatch_jmp !== 1'b1 || Dispatch_jmp_addr !== 32'h1000_0100 || dispatch_en !== 3'b000) begin
         n_bad++; $display("FAIL jump_pulse: got ren=%b jmp=%b addr=%h en=%b want 1 1 10000100 000",
            a_ren, Dispatch_jmp, Dispatch_jmp_addr, dispatch_en);
      end
      n_cmp++;
      ifetch_intruction = I_ADD;
      tick();
      if (a_ren !== 1'b0 || Dispatch_jmp !== 1'b0 || dispatch_en !== 3'b000) begin
         n_bad++; $display("FAIL jump_flush: got ren=%b jmp=%b en=%b want 0 0 000", a_ren, Dispatch_jmp, dispatch_en);
      end
      n_cmp++;
      tick();
      if (a_ren !== 1'b1 || dispatch_en !== 3'b001) begin
         n_bad++; $display("FAIL jump_resume: got ren=%b en=%b want 1 001", a_ren, dispatch_en);
      end
      n_cmp++;
      // Reset landing in the FLUSH cycle returns to RUN.
      ifetch_intruction = I_J;
      tick();
      reset = 0;
      tick();
      reset = 1;
      if (Dispatch_jmp !== 1'b0 || free_tag_count !== 6'd32 || Dispatch_jmp_addr !== 32'd0) begin
         n_bad++; $display("FAIL jump_reset: got jmp=%b cnt=%0d addr=%h want 0 32 0",
            Dispatch_jmp, free_tag_count, Dispatch_jmp_addr);
      end
      n_cmp++;
      ifetch_intruction = I_ADD;
      tick();
      ifetch_empty = 1;
      if (a_ren !== 1'b1 || dispatch_en !== 3'b001) begin
         n_bad++; $display("FAIL jump_reset_run: got ren=%b en=%b want 1 001", a_ren, dispatch_en);
      end
      n_cmp++;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0] rs, rt, rd;
      logic [31:0] ins;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
         0, 1:    ins = {6'h00, rs, rt, rd, 5'd0, 6'h20};
         2:       ins = {6'h00, rs, rt, rd, 5'd0, ($urandom_range(0, 1) != 0) ? 6'h18 : 6'h19};
         3:       ins = {6'h23, rs, rt, 16'($urandom)};
         4:       ins = {6'h2b, rs, rt, 16'($urandom)};
         5:       ins = {($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt, 16'($urandom)};
         6:       ins = {6'h02, 26'($urandom)};
         7:       ins = {6'h03, 26'($urandom)};
         default: ins = {6'h08, rs, rt, 16'($urandom)};
      endcase
      return ins;
   endfunction

   task automatic test_random();
      int k;
      do_reset();
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      for (int cyc = 0; cyc < 500; cyc++) begin
         ifetch_empty      = ($urandom_range(0, 99) < 20);
         ifetch_intruction = rand_instr();
         ifetch_pc_4       = $urandom;
         issueque_full     = NUM_Q'($urandom) & NUM_Q'($urandom);
         Cdb_valid = 0; Retire_valid = 0;
         if (outst.size() > 0 && $urandom_range(0, 99) < 30) begin
            k = $urandom_range(0, outst.size() - 1);
            Cdb_valid = 1; Cdb_rd_tag = 5'(outst[k].tag); Cdb_data = $urandom;
         end
         if (outst.size() > 0 && $urandom_range(0, 99) < 35) begin
            Retire_valid = 1; Retire_rd_tag = 5'(outst[0].tag);
            Retire_rd_reg = 5'(outst[0].reg_n); Retire_data = $urandom;
            void'(outst.pop_front());
         end
         tick();
         if (a_ren !== e_ren) begin
            n_bad++; $display("FAIL rnd_ren@%0d: got %b want %b", cyc, a_ren, e_ren);
         end
         n_cmp++;
         if (dispatch_en !== e_en || Dispatch_jmp !== e_jmp) begin
            n_bad++; $display("FAIL rnd_strobe@%0d: got en=%b jmp=%b want en=%b jmp=%b", cyc, dispatch_en, Dispatch_jmp, e_en, e_jmp);
         end
         n_cmp++;
         if (Dispatch_jmp_addr !== e_jaddr || dispatch_instr !== e_instr) begin
            n_bad++; $display("FAIL rnd_addr@%0d: got addr=%h instr=%h want %h %h", cyc, Dispatch_jmp_addr, dispatch_instr, e_jaddr, e_instr);
         end
         n_cmp++;
         if ({dispatch_rs_data, dispatch_rs_data_valid, dispatch_rs_tag} !== {e_rs_d, e_rs_v, e_rs_t}) begin
            n_bad++; $display("FAIL rnd_rs@%0d: got %h/%b/%0d want %h/%b/%0d", cyc,
               dispatch_rs_data, dispatch_rs_data_valid, dispatch_rs_tag, e_rs_d, e_rs_v, e_rs_t);
         end
         n_cmp++;
         if ({dispatch_rt_data, dispatch_rt_data_valid, dispatch_rt_tag} !== {e_rt_d, e_rt_v, e_rt_t}) begin
            n_bad++; $display("FAIL rnd_rt@%0d: got %h/%b/%0d want %h/%b/%0d", cyc,
               dispatch_rt_data, dispatch_rt_data_valid, dispatch_rt_tag, e_rt_d, e_rt_v, e_rt_t);
         end
         n_cmp++;
         if (dispatch_rd_tag !== e_rd_t || dispatch_rd_valid !== e_rd_v || int'(free_tag_count) != e_cnt) begin
            n_bad++; $display("FAIL rnd_rd@%0d: got rdt=%0d rdv=%b cnt=%0d want %0d %b %0d", cyc,
               dispatch_rd_tag, dispatch_rd_valid, free_tag_count, e_rd_t, e_rd_v, e_cnt);
         end
         n_cmp++;
      end
      idle_inputs();
   endtask

   initial begin
      reset = 0;
      idle_inputs();
      for (int i = 0; i < 32; i++) rf[i] = 32'(i * 16 + 3);
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      test_reset();
      test_basic_add();
      test_back_to_back();
      test_cdb_forward();
      test_queue_full();
      test_tag_exhaust();
      test_jump();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
